// File: rtl/operand_forward_ctrl.sv
// operand_forward_ctrl: forwarding and load-use control for EX operands.
// Tracks in-flight destinations and registers operand-mux selects.

package Mux3Type;
  typedef enum logic [1:0] {
    DEFAULT = 2'd0,
    TOP     = 2'd1,
    BOTTOM  = 2'd2,
    ZERO    = 2'd3
  } cmd_t;
endpackage

module operand_forward_ctrl
  import Mux3Type::*;
#(
  parameter int REG_ADDR_W  = 5,
  parameter bit ZERO_REG_EN = 1'b1,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   id_valid,
  output logic                   id_ready,
  input  logic [REG_ADDR_W-1:0]  id_rs1,
  input  logic [REG_ADDR_W-1:0]  id_rs2,
  input  logic                   id_rs1_used,
  input  logic                   id_rs2_used,
  input  logic [REG_ADDR_W-1:0]  id_rd,
  input  logic                   id_wb_en,
  input  logic                   id_is_load,
  input  logic                   pipe_hold,
  input  logic                   flush,
  output logic                   ex_valid,
  output cmd_t                   ex_op1_cmd,
  output cmd_t                   ex_op2_cmd,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  wb_en;
    logic                  is_load;
  } slot_t;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_t;

  slot_t  ex_q;
  slot_t  mem_q;
  slot_t  wb_q;
  state_t state_q;
  state_t state_d;

  logic   hazard;
  logic   accept;
  logic   stall_evt;
  cmd_t   op1_sel;
  cmd_t   op2_sel;

  function automatic logic is_zero(
    input logic [REG_ADDR_W-1:0] s,
    input logic                  used
  );
    return !used || (ZERO_REG_EN && (s == '0));
  endfunction

  function automatic logic hit(
    input slot_t                 sl,
    input logic [REG_ADDR_W-1:0] s
  );
    return sl.valid && sl.wb_en && (sl.rd == s);
  endfunction

  // Youngest producer wins; a WB-slot producer is already in the
  // register file because writes pass straight through.
  function automatic cmd_t pick(
    input logic [REG_ADDR_W-1:0] s,
    input logic                  used,
    input slot_t                 ex_s,
    input slot_t                 mem_s,
    input slot_t                 wb_s
  );
    cmd_t c;
    c = DEFAULT;
    if (is_zero(s, used))
      c = ZERO;
    else if (hit(ex_s, s))
      c = TOP;
    else if (hit(mem_s, s))
      c = BOTTOM;
    else if (hit(wb_s, s))
      c = DEFAULT;
    return c;
  endfunction

  function automatic logic load_hit(
    input slot_t                 sl,
    input logic [REG_ADDR_W-1:0] s,
    input logic                  used
  );
    return sl.is_load && !is_zero(s, used) && hit(sl, s);
  endfunction

  // In STALL the EX slot is the bubble, so no hazard can be seen.
  assign hazard = (state_q == RUN) &&
                  (load_hit(ex_q, id_rs1, id_rs1_used) ||
                   load_hit(ex_q, id_rs2, id_rs2_used));

  assign id_ready  = !pipe_hold && !hazard && !flush;
  assign accept    = id_valid && id_ready;
  assign stall_evt = id_valid && hazard && !flush && !pipe_hold;

  assign op1_sel = pick(id_rs1, id_rs1_used, ex_q, mem_q, wb_q);
  assign op2_sel = pick(id_rs2, id_rs2_used, ex_q, mem_q, wb_q);

  // Next-state: enter STALL on a bubble insertion, leave next advance.
  always_comb begin
    state_d = state_q;
    if (!pipe_hold) begin
      if (flush) begin
        state_d = RUN;
      end else begin
        unique case (state_q)
          RUN:     if (stall_evt) state_d = STALL;
          STALL:   state_d = RUN;
          default: state_d = RUN;
        endcase
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_q <= RUN;
    else
      state_q <= state_d;
  end

  // Shadow pipeline advance; flush kills EX and MEM contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else if (!pipe_hold) begin
      wb_q <= mem_q;
      if (flush)
        mem_q <= '0;
      else
        mem_q <= ex_q;
      if (accept) begin
        ex_q.valid   <= 1'b1;
        ex_q.rd      <= id_rd;
        ex_q.wb_en   <= id_wb_en;
        ex_q.is_load <= id_is_load;
      end else begin
        ex_q <= '0;
      end
    end
  end

  // Registered selects for the instruction entering EX.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid   <= 1'b0;
      ex_op1_cmd <= ZERO;
      ex_op2_cmd <= ZERO;
    end else if (!pipe_hold) begin
      ex_valid   <= accept;
      ex_op1_cmd <= accept ? op1_sel : ZERO;
      ex_op2_cmd <= accept ? op2_sel : ZERO;
    end
  end

  // Saturating count of inserted load-use bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt <= '0;
    else if (stall_evt && (stall_cnt != '1))
      stall_cnt <= stall_cnt + 1'b1;
  end

endmodule
